// File: rtl/add64_seq16_pkg.sv
// Shared arithmetic definitions for the sequential wide adder.
//  - state_t  : controller state encoding (2-bit)
//  - SLICE_W  : width of the slice the block CLA works on
//  - gp_merge : combine a high and a low generate/propagate pair into one group pair
package arith_defs;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // {G, P} of the concatenated group (hi above lo).
  function automatic logic [1:0] gp_merge(input logic g_hi, input logic p_hi,
                                          input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

endpackage

// File: rtl/add64_seq16_cla.sv
// cla16: 16-bit two-level block carry-lookahead adder.
//  Four 4-bit lookahead groups; a second lookahead level generates the group
//  carry-ins directly from cin. Exports block generate/propagate so the caller
//  forms the carry-out as g | (p & cin).
// Ports:
//  a, b  in  16  addends
//  cin   in  1   carry in
//  sum   out 16  a + b + cin (mod 2^16)
//  g, p  out 1   block generate / propagate
module cla16
  import arith_defs::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        g,
  output logic        p
);

  logic [15:0] bg;   // bit generate
  logic [15:0] bp;   // bit propagate
  logic [15:0] c;    // carry into each bit
  logic [3:0]  gg;   // group generate
  logic [3:0]  gpr;  // group propagate
  logic [3:0]  gc;   // carry into each group

  assign bg = a & b;
  assign bp = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [3:0] lg, lp;
    assign lg = bg[4*k +: 4];
    assign lp = bp[4*k +: 4];

    assign gg[k]  = lg[3]
                  | (lp[3] & lg[2])
                  | (lp[3] & lp[2] & lg[1])
                  | (lp[3] & lp[2] & lp[1] & lg[0]);
    assign gpr[k] = &lp;

    assign c[4*k]   = gc[k];
    assign c[4*k+1] = lg[0] | (lp[0] & gc[k]);
    assign c[4*k+2] = lg[1] | (lp[1] & lg[0]) | (lp[1] & lp[0] & gc[k]);
    assign c[4*k+3] = lg[2] | (lp[2] & lg[1]) | (lp[2] & lp[1] & lg[0])
                    | (lp[2] & lp[1] & lp[0] & gc[k]);
  end

  // Second-level lookahead: group carries straight from cin, no inter-group ripple.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gpr[0] & cin);
  assign gc[2] = gg[1] | (gpr[1] & gg[0]) | (gpr[1] & gpr[0] & cin);
  assign gc[3] = gg[2] | (gpr[2] & gg[1]) | (gpr[2] & gpr[1] & gg[0])
               | (gpr[2] & gpr[1] & gpr[0] & cin);

  // Block G/P as a balanced merge tree.
  logic [1:0] gp_lo, gp_hi, gp_all;
  assign gp_lo  = gp_merge(gg[1], gpr[1], gg[0], gpr[0]);
  assign gp_hi  = gp_merge(gg[3], gpr[3], gg[2], gpr[2]);
  assign gp_all = gp_merge(gp_hi[1], gp_hi[0], gp_lo[1], gp_lo[0]);
  assign g      = gp_all[1];
  assign p      = gp_all[0];

  assign sum = bp ^ c;

endmodule

// File: rtl/add64_seq16.sv
// add64_seq16: multi-cycle WIDTH-bit adder/subtractor built around one cla16.
//  One 16-bit slice per clock, LSB slice first; a carry flop links slices.
//  start accepted in IDLE only; done pulses one cycle with Sum/Cout/Ovf valid.
//  Latency: accept edge + NCHUNK RUN edges + 1 FIN edge -> done.
// Ports:
//  clk, reset   clock (rising), asynchronous active-high reset
//  start        request, ignored while busy
//  sub          0: A+B+Cin, 1: A-B
//  Cin          carry in (ignored when sub=1)
//  A, B         operands, sampled on accepted start
//  Sum          result, held until next accepted start (updated slice-wise during RUN)
//  Cout         carry out of MSB (sub: 1 = no borrow)
//  Ovf          signed overflow
//  busy         state != IDLE
//  done         one-cycle result-valid pulse
// WIDTH must be a multiple of 16 and at least 32.
module add64_seq16
  import arith_defs::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / SLICE_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               carry;
  logic               last;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_g, sl_p;

  assign last = (cnt == CNT_W'(NCHUNK - 1));
  assign busy = (state != ST_IDLE);

  // Slice select: indexed part-select on the latched operands.
  assign sl_a = a_r[cnt*SLICE_W +: SLICE_W];
  assign sl_b = b_r[cnt*SLICE_W +: SLICE_W];

  cla16 u_cla (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry),
    .sum (sl_sum),
    .g   (sl_g),
    .p   (sl_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_FIN;
      ST_FIN:             state_nx = ST_IDLE;
      default:            state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            // Subtract as A + ~B + 1; inversion uses sub as sampled here.
            a_r   <= A;
            b_r   <= B ^ {WIDTH{sub}};
            carry <= sub | Cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          Sum[cnt*SLICE_W +: SLICE_W] <= sl_sum;
          carry <= sl_g | (sl_p & carry);
          // Hold on the last slice so cnt never wraps.
          if (!last) cnt <= cnt + 1'b1;
        end
        ST_FIN: begin
          Cout <= carry;
          // b_r already holds ~B for subtract, so one rule covers both ops.
          Ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (Sum[WIDTH-1] != a_r[WIDTH-1]);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
